// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Purpose  : Shared types and helpers for the trace capture engine: FSM
//             state encoding, transmit byte width and capture-length clamp.
//  Revision : 1.0  initial release
// ============================================================================
package trace_pkg;

  // Byte width of the readout stream
  localparam int TX_W = 8;

  // Capture engine states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4,
    S_READOUT = 3'd5
  } state_e;

  // A requested length of zero or one beyond the buffer means "fill the buffer"
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
//  Module   : trace_ram
//  Purpose  : Simple dual-port trace buffer, DEPTH x SAMPLE_W, synchronous
//             write and registered read so it maps onto block RAM.
//  Revision : 1.0  initial release
// ============================================================================
module trace_ram #(
  parameter int SAMPLE_W = 7,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rdata_q;

  // Write port: one sample per enabled cycle
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: free-running registered read, re-reading the same address
  // keeps the output stable
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/trace_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture_ctrl
//  Purpose  : Arm / trigger / delayed capture of sensor samples into a block
//             RAM trace buffer, then byte-wise readout over valid/ready.
//             Optional build macro TRACE_DECIM_EN adds a decim[3:0] input
//             that keeps only every (decim+1)-th sample during capture.
//  Revision : 1.0  initial release
// ============================================================================
module trace_capture_ctrl
  import trace_pkg::*;
#(
  parameter int SAMPLE_W = 7,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 9,
  parameter int DLY_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                trigger,
  input  logic [DLY_W-1:0]    trig_delay,
  input  logic [ADDR_W:0]     capture_len,
`ifdef TRACE_DECIM_EN
  input  logic [3:0]          decim,
`endif
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                rd_start,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [TX_W-1:0]     tx_data,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_ADR_ONE = ADDR_W'(1);
  localparam logic [DLY_W-1:0]  C_DLY_ONE = DLY_W'(1);

  state_e              state_q;
  logic [ADDR_W:0]     len_q;
  logic [DLY_W-1:0]    delay_q;
  logic [ADDR_W:0]     waddr_q;
  logic [ADDR_W:0]     raddr_q;
  logic                tx_valid_q;

  logic                keep_w;
  logic                wr_en_w;
  logic                hs_w;
  logic                last_wr_w;
  logic                last_rd_w;
  logic [ADDR_W-1:0]   ram_raddr_w;
  logic [SAMPLE_W-1:0] rdata_w;

`ifdef TRACE_DECIM_EN
  logic [3:0]          decim_q;
  logic [3:0]          dcnt_q;
  // Keep the sample when the decimation phase counter is at zero
  assign keep_w = (dcnt_q == 4'd0);
`else
  assign keep_w = 1'b1;
`endif

  assign wr_en_w   = (state_q == S_CAPTURE) && sample_valid && keep_w;
  assign hs_w      = tx_valid_q && tx_ready;
  assign last_wr_w = (waddr_q == (len_q - C_CNT_ONE));
  assign last_rd_w = ((raddr_q + C_CNT_ONE) == len_q);

  // Prefetch: on a handshake the next address goes to the RAM in the same
  // cycle so the following byte is ready one clock later. Outside readout
  // address 0 is presented so the DONE->READOUT edge fetches the first entry.
  always_comb begin
    ram_raddr_w = '0;
    if (state_q == S_READOUT) begin
      ram_raddr_w = hs_w ? (raddr_q[ADDR_W-1:0] + C_ADR_ONE) : raddr_q[ADDR_W-1:0];
    end
  end

  trace_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en_w),
    .waddr_i (waddr_q[ADDR_W-1:0]),
    .wdata_i (sample),
    .raddr_i (ram_raddr_w),
    .rdata_o (rdata_w)
  );

  // Capture/readout state machine with its counters and the tx_valid flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      delay_q    <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      tx_valid_q <= 1'b0;
`ifdef TRACE_DECIM_EN
      decim_q    <= '0;
      dcnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_q <= S_ARMED;
            delay_q <= trig_delay;
            len_q   <= (ADDR_W+1)'(clamp_len(32'(capture_len), 32'(DEPTH)));
            waddr_q <= '0;
            raddr_q <= '0;
`ifdef TRACE_DECIM_EN
            decim_q <= decim;
`endif
          end
        end
        S_ARMED: begin
          if (trigger) begin
            state_q <= (delay_q != '0) ? S_DELAY : S_CAPTURE;
`ifdef TRACE_DECIM_EN
            dcnt_q  <= '0;
`endif
          end
        end
        S_DELAY: begin
          // The sample that brings the count to zero is consumed, not stored
          if (sample_valid) begin
            delay_q <= delay_q - C_DLY_ONE;
            if (delay_q == C_DLY_ONE) begin
              state_q <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
`ifdef TRACE_DECIM_EN
            dcnt_q <= (dcnt_q == decim_q) ? 4'd0 : (dcnt_q + 4'd1);
`endif
            if (keep_w) begin
              waddr_q <= waddr_q + C_CNT_ONE;
              if (last_wr_w) begin
                state_q <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (rd_start) begin
            state_q    <= S_READOUT;
            raddr_q    <= '0;
            tx_valid_q <= 1'b1;
          end
        end
        S_READOUT: begin
          if (hs_w) begin
            if (last_rd_w) begin
              state_q    <= S_IDLE;
              tx_valid_q <= 1'b0;
            end else begin
              raddr_q <= raddr_q + C_CNT_ONE;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_valid_q ? TX_W'(rdata_w) : '0;
  assign busy     = (state_q == S_ARMED) || (state_q == S_DELAY) ||
                    (state_q == S_CAPTURE) || (state_q == S_READOUT);
  assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_trace_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_capture_ctrl
//  Purpose  : Self-checking bench for trace_capture_ctrl: table of capture /
//             readout scenarios plus hand-written corner sequences; stored
//             samples are predicted into a queue and popped on each byte.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trace_capture_ctrl;

  localparam int SAMPLE_W = 7;
  localparam int DEPTH    = 512;
  localparam int ADDR_W   = 9;
  localparam int DLY_W    = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                arm = 1'b0;
  logic                trigger = 1'b0;
  logic [DLY_W-1:0]    trig_delay = '0;
  logic [ADDR_W:0]     capture_len = '0;
`ifdef TRACE_DECIM_EN
  logic [3:0]          decim = 4'd0;
`endif
  logic                sample_valid = 1'b0;
  logic [SAMPLE_W-1:0] sample = '0;
  logic                rd_start = 1'b0;
  logic                tx_valid;
  logic                tx_ready = 1'b0;
  logic [7:0]          tx_data;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  trace_capture_ctrl #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .DLY_W    (DLY_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .trigger      (trigger),
    .trig_delay   (trig_delay),
    .capture_len  (capture_len),
`ifdef TRACE_DECIM_EN
    .decim        (decim),
`endif
    .sample_valid (sample_valid),
    .sample       (sample),
    .rd_start     (rd_start),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Arm, trigger and feed dly+len consecutive samples; predicted bytes go to exp_q
  task automatic run_capture(input int dly, input int len, input int start, input int gap);
    int eff;
    int n;
    eff = ((len == 0) || (len > DEPTH)) ? DEPTH : len;
    n   = dly + eff;
    trig_delay  = DLY_W'(dly);
    capture_len = (ADDR_W+1)'(len);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("armed_busy", busy, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check("pre_done", done, 0);
      sample_valid = 1'b1;
      sample = SAMPLE_W'(start + i);
      if (i >= dly) exp_q.push_back(8'((start + i) % 128));
      tick();
      sample_valid = 1'b0;
      if ((gap != 0) && (i < n - 1)) tick();
    end
    check("done_set", done, 1);
    check("done_busy", busy, 0);
  endtask

  // Pulse rd_start and drain n bytes; mode 0 = always ready, 1 = ready 1 of 3
  task automatic do_readout(input int n, input int mode, output int got,
                            output int first_b, output int last_b);
    int cyc;
    logic stalled;
    logic [7:0] held;
    logic [7:0] e;
    got = 0; first_b = -1; last_b = -1; stalled = 1'b0; held = '0; cyc = 0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while ((got < n) && (cyc < 4 * n + 20)) begin
      tx_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
      if (stalled) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, held);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", tx_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("byte", tx_data, e);
        end
        if (got == 0) first_b = tx_data;
        last_b  = tx_data;
        got++;
        stalled = 1'b0;
      end else begin
        stalled = tx_valid;
        held    = tx_data;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    check("rd_count", got, n);
    check("end_valid", tx_valid, 0);
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    int dly;
    int len;
    int start;
    int gap;
    int mode;
    int exp_n;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int got;
    int fb;
    int lb;

    vecs[0] = '{dly:0, len:16,  start:0,    gap:0, mode:0, exp_n:16,  exp_first:'h00, exp_last:'h0F};
    vecs[1] = '{dly:3, len:4,   start:10,   gap:1, mode:0, exp_n:4,   exp_first:'h0D, exp_last:'h10};
    vecs[2] = '{dly:0, len:0,   start:0,    gap:0, mode:0, exp_n:512, exp_first:'h00, exp_last:'h7F};
    vecs[3] = '{dly:0, len:600, start:5,    gap:0, mode:1, exp_n:512, exp_first:'h05, exp_last:'h04};
    vecs[4] = '{dly:2, len:5,   start:'h70, gap:0, mode:1, exp_n:5,   exp_first:'h72, exp_last:'h76};
    vecs[5] = '{dly:0, len:1,   start:'h33, gap:0, mode:0, exp_n:1,   exp_first:'h33, exp_last:'h33};

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Trigger in IDLE is ignored
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("trig_idle_busy", busy, 0);

    // Scenario table
    for (int v = 0; v < 6; v++) begin
      run_capture(vecs[v].dly, vecs[v].len, vecs[v].start, vecs[v].gap);
      do_readout(vecs[v].exp_n, vecs[v].mode, got, fb, lb);
      check($sformatf("vec%0d_count", v), got, vecs[v].exp_n);
      check($sformatf("vec%0d_first", v), fb, vecs[v].exp_first);
      check($sformatf("vec%0d_last", v), lb, vecs[v].exp_last);
    end

    // Same-cycle arm+trigger only arms; samples in ARMED are not stored
    trig_delay  = '0;
    capture_len = (ADDR_W+1)'(1);
    arm = 1'b1; trigger = 1'b1;
    tick();
    arm = 1'b0; trigger = 1'b0;
    check("armtrig_busy", busy, 1);
    sample_valid = 1'b1; sample = 7'h55;
    tick();
    sample_valid = 1'b0;
    check("armed_nostore_done", done, 0);
    check("armed_still_busy", busy, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    sample_valid = 1'b1; sample = 7'h21; exp_q.push_back(8'h21);
    tick();
    sample_valid = 1'b0;
    check("armtrig_done", done, 1);
    do_readout(1, 0, got, fb, lb);
    check("armtrig_byte", fb, 'h21);

    // rd_start during CAPTURE is ignored
    capture_len = (ADDR_W+1)'(3);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    sample_valid = 1'b1; sample = 7'h40; exp_q.push_back(8'h40);
    tick();
    sample_valid = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("rdcap_tx_valid", tx_valid, 0);
    check("rdcap_busy", busy, 1);
    check("rdcap_done", done, 0);
    for (int i = 1; i < 3; i++) begin
      sample_valid = 1'b1; sample = SAMPLE_W'('h40 + i); exp_q.push_back(8'('h40 + i));
      tick();
    end
    sample_valid = 1'b0;
    check("rdcap_done_after", done, 1);
    do_readout(3, 1, got, fb, lb);
    check("rdcap_last", lb, 'h42);

    // Reset in the middle of a capture
    capture_len = (ADDR_W+1)'(8);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    sample_valid = 1'b1;
    repeat (2) tick();
    sample_valid = 1'b0;
    check("midcap_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_tx_valid", tx_valid, 0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("midrst_rd_ignored", tx_valid, 0);
    check("midrst_rd_busy", busy, 0);

`ifdef TRACE_DECIM_EN
    // Decimation by 2: keep samples 0,2,4,6
    decim = 4'd1;
    trig_delay = '0;
    capture_len = (ADDR_W+1)'(4);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    decim = 4'd0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("decim_pre_done", done, 0);
      sample_valid = 1'b1; sample = SAMPLE_W'(i);
      if ((i % 2) == 0) exp_q.push_back(8'(i));
      tick();
    end
    sample_valid = 1'b0;
    check("decim_done", done, 1);
    do_readout(4, 0, got, fb, lb);
    check("decim_last", lb, 'h06);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
